instr_sequencer: RTL and testbench

- Upstream feeder for mipscpu: buffers a short program of 32-bit MIPS instruction words and replays them onto the CPU's instrWord/newInstr inputs.
- Enforces a fixed issue spacing so each multi-cycle instruction completes before the next one arrives.
- Replaces hand-timed testbench stimulus with a loadable, self-timed instruction stream and reports completion to the bench or system controller.

---
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Buffers a short program of 32-bit MIPS words and replays them
//            to the CPU with a fixed spacing between newInstr strobes.
// Revision : 1.0  initial release
// ============================================================================
module instr_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int GAP    = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              loadEn,
  input  logic [31:0]       loadWord,
  input  logic              start,
  output logic [31:0]       instrWord,
  output logic              newInstr,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [7:0]      c_GAP_RELOAD = 8'(GAP - 3);
  localparam logic [ADDR_W:0] c_DEPTH      = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t              r_state;
  logic [31:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_head;
  logic [ADDR_W-1:0]   r_tail;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_gap;
  logic [31:0]         r_instr;
  logic                r_new;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;

  logic                w_idle;
  logic                w_full;
  logic                w_load_ok;
  logic                w_load_rej;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_full     = (r_count == c_DEPTH);
  assign w_load_ok  = loadEn && w_idle && !w_full;
  assign w_load_rej = loadEn && !w_load_ok;

  // Storage carries no reset: pointers and count define what is valid.
  always_ff @(posedge Clk) begin
    if (w_load_ok) begin
      r_mem[r_tail] <= loadWord;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_gap   <= '0;
      r_instr <= '0;
      r_new   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_new  <= 1'b0;
      r_done <= 1'b0;

      if (w_load_ok) begin
        r_tail  <= r_tail + ADDR_W'(1);
        r_count <= r_count + (ADDR_W + 1)'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            // A word accepted alongside start joins this run.
            if ((r_count != '0) || w_load_ok) begin
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_FIN;
            end
          end
        end

        ST_SETUP: begin
          r_instr <= r_mem[r_head];
          r_head  <= r_head + ADDR_W'(1);
          r_count <= r_count - (ADDR_W + 1)'(1);
          r_state <= ST_STROBE;
        end

        ST_STROBE: begin
          r_new   <= 1'b1;
          r_gap   <= c_GAP_RELOAD;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (r_gap == 8'd0) begin
            r_state <= (r_count != '0) ? ST_SETUP : ST_FIN;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end

        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      // A rejected load wins over the clear from a same-cycle start.
      if (w_load_rej) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign instrWord = r_instr;
  assign newInstr  = r_new;
  assign busy      = r_busy;
  assign done      = r_done;
  assign full      = w_full;
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Directed, self-checking bench for instr_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int GAP    = 12;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              loadEn = 1'b0;
  logic [31:0]       loadWord = '0;
  logic              start = 1'b0;
  logic [31:0]       instrWord;
  logic              newInstr, busy, done, full, empty, overflow;
  logic [ADDR_W:0]   count;

  instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
    .Clk(Clk), .Reset(Reset), .loadEn(loadEn), .loadWord(loadWord),
    .start(start), .instrWord(instrWord), .newInstr(newInstr), .busy(busy),
    .done(done), .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model: run schedule from edge arithmetic ----
  logic [31:0] q[$];
  bit          mdl_on = 0;
  bit          run_on = 0;
  int          run_n, run_k, run_end;
  logic [31:0] m_instr;
  bit          m_ovf;
  bit          m_idle;

  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      q.delete();
      run_on  = 0;
      m_instr = '0;
      m_ovf   = 0;
      mdl_on  = 1;
    end else if (mdl_on) begin
      m_idle = !(run_on && cyc > run_n && cyc <= run_end);
      if (m_idle) begin
        if (start) m_ovf = 0;
        if (loadEn) begin
          if (q.size() < DEPTH) q.push_back(loadWord);
          else m_ovf = 1;
        end
        if (start) begin
          run_on  = 1;
          run_n   = cyc;
          run_k   = q.size();
          run_end = run_n + 1 + run_k * GAP;
        end
      end else begin
        if (loadEn) m_ovf = 1;
        if (((cyc - run_n - 1) % GAP == 0) && ((cyc - run_n - 1) / GAP < run_k))
          m_instr = q.pop_front();
      end
    end
  end

  int d_strobe;
  bit e_new, e_done, e_busy;

  always @(negedge Clk) begin
    if (mdl_on) begin
      d_strobe = cyc - run_n - 2;
      e_new  = run_on && d_strobe >= 0 && (d_strobe % GAP == 0) && (d_strobe / GAP < run_k);
      e_done = run_on && cyc == run_end;
      e_busy = run_on && cyc >= run_n && cyc < run_end;
      chk("instrWord", instrWord, m_instr);
      chk("newInstr", {31'd0, newInstr}, {31'd0, e_new});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("count", {27'd0, count}, q.size());
      chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
      chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // ---------------- observers and a tiny MIPS executor -------------------
  int          pulses[$];
  logic [31:0] seen[$];
  int          done_cnt, done_cyc, busy_cnt;
  logic [31:0] regs [32];
  logic [31:0] dmem [16];

  task automatic exec(input logic [31:0] w);
    logic [31:0] ea;
    ea = regs[w[25:21]] + {{16{w[15]}}, w[15:0]};
    case (w[31:26])
      6'h23: if (w[20:16] != 5'd0) regs[w[20:16]] = dmem[ea[3:0]];
      6'h2B: dmem[ea[3:0]] = regs[w[20:16]];
      6'h00: if (w[15:11] != 5'd0) begin
        if (w[5:0] == 6'h20) regs[w[15:11]] = regs[w[25:21]] + regs[w[20:16]];
        else if (w[5:0] == 6'h22) regs[w[15:11]] = regs[w[25:21]] - regs[w[20:16]];
      end
      default: ;
    endcase
  endtask

  always @(negedge Clk) begin
    if (mdl_on) begin
      if (newInstr) begin
        pulses.push_back(cyc);
        seen.push_back(instrWord);
        exec(instrWord);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic nstep();
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_obs();
    pulses.delete();
    seen.delete();
    done_cnt = 0;
    busy_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    nstep();
    nstep();
    Reset = 1'b0;
    clear_obs();
  endtask

  task automatic load(input logic [31:0] w);
    loadEn = 1'b1;
    loadWord = w;
    nstep();
    loadEn = 1'b0;
  endtask

  task automatic pulse_start(output int n);
    n = cyc + 1;
    start = 1'b1;
    nstep();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < (DEPTH + 2) * GAP + 20; i++) begin
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
      nstep();
    end
    chk({name, "_done_within_budget"}, {31'd0, ok}, 32'd1);
  endtask

  logic [31:0] prog [6];
  int n0;
  int cnt_before;

  initial begin
    prog[0] = 32'h8C01_0000;  // lw  $1,0($0)
    prog[1] = 32'h8C02_0001;  // lw  $2,1($0)
    prog[2] = 32'h8C03_0002;  // lw  $3,2($0)
    prog[3] = 32'h0022_2020;  // add $4,$1,$2
    prog[4] = 32'h0083_2022;  // sub $4,$4,$3
    prog[5] = 32'hAC04_0003;  // sw  $4,3($0)
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    dmem[0] = 32'd10; dmem[1] = 32'd22; dmem[2] = 32'd6;

    // reset state
    do_reset();
    chk("rst_instrWord", instrWord, 32'd0);
    chk("rst_newInstr", {31'd0, newInstr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);

    // program d = a + b - c
    for (int i = 0; i < 6; i++) load(prog[i]);
    chk("t1_count", {27'd0, count}, 32'd6);
    pulse_start(n0);
    wait_done("t1");
    chk("t1_pulses", pulses.size(), 32'd6);
    chk("t1_first_strobe", pulses[0], n0 + 2);
    for (int i = 1; i < pulses.size(); i++) chk("t1_gap", pulses[i] - pulses[i-1], 32'd12);
    for (int i = 0; i < seen.size() && i < 6; i++) chk("t1_word", seen[i], prog[i]);
    chk("t1_done_cycle", done_cyc, n0 + 1 + 6 * 12);
    nstep();
    chk("t1_done_once", done_cnt, 32'd1);
    chk("t1_dmem3", dmem[3], 32'd26);

    // overfill, then a second full run across the pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) load(32'h1000 + i);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_no_ovf_yet", {31'd0, overflow}, 32'd0);
    load(32'h1010);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_count", {27'd0, count}, 32'd16);
    pulse_start(n0);
    chk("t2_ovf_cleared", {31'd0, overflow}, 32'd0);
    wait_done("t2a");
    chk("t2_pulses", pulses.size(), 32'd16);
    for (int i = 0; i < seen.size() && i < 16; i++) chk("t2_word", seen[i], 32'h1000 + i);
    nstep();
    clear_obs();
    for (int i = 0; i < 16; i++) load(32'h2000 + i);
    pulse_start(n0);
    wait_done("t2b");
    chk("t2b_pulses", pulses.size(), 32'd16);
    for (int i = 0; i < seen.size() && i < 16; i++) chk("t2b_word", seen[i], 32'h2000 + i);
    chk("t2b_done_cycle", done_cyc, n0 + 1 + 16 * 12);

    // start on an empty buffer
    do_reset();
    nstep();
    pulse_start(n0);
    wait_done("t3");
    nstep();
    nstep();
    chk("t3_done_cycle", done_cyc, n0 + 1);
    chk("t3_no_pulse", pulses.size(), 32'd0);
    chk("t3_busy_cycles", busy_cnt, 32'd1);
    chk("t3_done_once", done_cnt, 32'd1);

    // reset one cycle after the second strobe
    do_reset();
    for (int i = 0; i < 6; i++) load(32'h3000 + i);
    pulse_start(n0);
    for (int i = 0; i < 4 * GAP && pulses.size() < 2; i++) nstep();
    chk("t4_reached_second", pulses.size(), 32'd2);
    Reset = 1'b1;
    nstep();
    Reset = 1'b0;
    chk("t4_instrWord", instrWord, 32'd0);
    chk("t4_count", {27'd0, count}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8 * GAP; i++) nstep();
    chk("t4_no_more_pulses", pulses.size(), 32'd2);
    chk("t4_no_done", done_cnt, 32'd0);

    // load rejected while a run is waiting
    do_reset();
    for (int i = 0; i < 3; i++) load(32'h4000 + i);
    pulse_start(n0);
    for (int i = 0; i < 2 * GAP && pulses.size() < 1; i++) nstep();
    nstep();
    nstep();
    cnt_before = 2;
    load(32'hDEAD_BEEF);
    chk("t5_count_unchanged", {27'd0, count}, cnt_before);
    chk("t5_ovf_set", {31'd0, overflow}, 32'd1);
    wait_done("t5");
    chk("t5_pulses", pulses.size(), 32'd3);
    for (int i = 0; i < seen.size() && i < 3; i++) chk("t5_word", seen[i], 32'h4000 + i);
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    nstep();
    clear_obs();
    load(32'h4100);
    pulse_start(n0);
    chk("t5_ovf_cleared", {31'd0, overflow}, 32'd0);
    wait_done("t5b");

    // load and start together on an empty buffer
    do_reset();
    loadEn = 1'b1;
    loadWord = 32'h5A5A_1234;
    n0 = cyc + 1;
    start = 1'b1;
    nstep();
    loadEn = 1'b0;
    start = 1'b0;
    wait_done("t6");
    nstep();
    chk("t6_pulses", pulses.size(), 32'd1);
    if (seen.size() > 0) chk("t6_word", seen[0], 32'h5A5A_1234);
    chk("t6_done_cycle", done_cyc, n0 + 1 + 12);
    chk("t6_done_once", done_cnt, 32'd1);

    nstep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
